// File: rtl/rv32_branch_resolve_unit.sv
// rv32_branch_resolve_unit
// Registers branch/jump resolution for one instruction per cycle: the actual
// next PC, the taken flag, the mispredict flag against the front-end
// prediction, and an illegal-funct3 flag. It also keeps a direct-mapped table
// of 2-bit saturating counters for front-end lookups, and two saturating
// statistics counters.
module rv32_branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    input  logic [4:0]       opcode_in,
    input  logic [2:0]       funct3_in,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [XLEN-1:0]  rs1_in,
    input  logic [XLEN-1:0]  rs2_in,
    input  logic [XLEN-1:0]  pred_next_pc_in,
    input  logic             flush_in,
    input  logic [XLEN-1:0]  lookup_pc_in,
    output logic             lookup_taken_out,
    output logic             valid_out,
    output logic             taken_out,
    output logic [XLEN-1:0]  next_pc_out,
    output logic             mispredict_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] branch_cnt_out,
    output logic [CNT_W-1:0] mispred_cnt_out
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // Decode and resolution results for the request on the inputs
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            capture;
    logic            illegal;
    logic            cond_true;
    logic            taken;
    logic            bht_update;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] next_pc;
    logic            mispredict;
    logic [IDX_W-1:0] bht_idx;
    logic [IDX_W-1:0] lookup_idx;

    // Registered state
    logic             valid_q,       valid_d;
    logic             taken_q,       taken_d;
    logic [XLEN-1:0]  next_pc_q,     next_pc_d;
    logic             mispredict_q,  mispredict_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];

    // Only the index bits of the lookup address select a counter
    logic unused_lookup_bits;
    assign unused_lookup_bits = ^{lookup_pc_in[XLEN-1:IDX_W+2], lookup_pc_in[1:0]};

    assign bht_idx    = pc_in[IDX_W+1:2];
    assign lookup_idx = lookup_pc_in[IDX_W+1:2];

    // Decode the opcode, evaluate the branch condition and form the actual next PC
    always_comb begin
        is_branch  = (opcode_in == OP_BRANCH);
        is_jal     = (opcode_in == OP_JAL);
        is_jalr    = (opcode_in == OP_JALR);
        capture    = valid_in && !flush_in && (is_branch || is_jal || is_jalr);
        illegal    = is_branch && (funct3_in[2:1] == 2'b01);
        cond_true  = 1'b0;
        unique case (funct3_in)
            3'b000:  cond_true = (rs1_in == rs2_in);
            3'b001:  cond_true = (rs1_in != rs2_in);
            3'b100:  cond_true = ($signed(rs1_in) <  $signed(rs2_in));
            3'b101:  cond_true = ($signed(rs1_in) >= $signed(rs2_in));
            3'b110:  cond_true = (rs1_in <  rs2_in);
            3'b111:  cond_true = (rs1_in >= rs2_in);
            default: cond_true = 1'b0;
        endcase
        taken      = is_jal || is_jalr || (is_branch && !illegal && cond_true);
        jalr_sum   = rs1_in + imm_in;
        if (is_jalr) begin
            next_pc = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (taken) begin
            next_pc = pc_in + imm_in;
        end else begin
            next_pc = pc_in + XLEN'(4);
        end
        mispredict = (next_pc != pred_next_pc_in);
        bht_update = capture && is_branch && !illegal;
    end

    // Next values of the result registers and the saturating statistics counters
    always_comb begin
        valid_d       = capture;
        taken_d       = capture && taken;
        next_pc_d     = capture ? next_pc : '0;
        mispredict_d  = capture && mispredict;
        illegal_d     = capture && illegal;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bht_update && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (capture && mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // Next BHT contents: move the addressed counter toward the resolved direction
    always_comb begin
        bht_d = bht_q;
        if (bht_update) begin
            if (taken && (bht_q[bht_idx] != 2'b11)) begin
                bht_d[bht_idx] = bht_q[bht_idx] + 2'b01;
            end else if (!taken && (bht_q[bht_idx] != 2'b00)) begin
                bht_d[bht_idx] = bht_q[bht_idx] - 2'b01;
            end
        end
    end

    // Result and counter registers; reset clears everything, dropping any in-flight result
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q       <= 1'b0;
            taken_q       <= 1'b0;
            next_pc_q     <= '0;
            mispredict_q  <= 1'b0;
            illegal_q     <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            taken_q       <= taken_d;
            next_pc_q     <= next_pc_d;
            mispredict_q  <= mispredict_d;
            illegal_q     <= illegal_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // BHT storage; every counter starts weakly not-taken
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            bht_q <= bht_d;
        end
    end

    assign lookup_taken_out = bht_q[lookup_idx][1];
    assign valid_out        = valid_q;
    assign taken_out        = taken_q;
    assign next_pc_out      = next_pc_q;
    assign mispredict_out   = mispredict_q;
    assign illegal_out      = illegal_q;
    assign branch_cnt_out   = branch_cnt_q;
    assign mispred_cnt_out  = mispred_cnt_q;

endmodule

// File: tb/tb_rv32_branch_resolve_unit.sv
// Testbench for rv32_branch_resolve_unit: directed cases plus random traffic.
// Expected results come from a behavioural model and are queued per cycle;
// a monitor process pops and compares them after each capture edge. A second
// instance with narrow counters shares the stimulus to reach saturation.
module tb_rv32_branch_resolve_unit;

    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_JAL  = 5'b11011;
    localparam logic [4:0] OP_JALR = 5'b11001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, flush_in;
    logic [4:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic [31:0] pc_in, imm_in, rs1_in, rs2_in, pred_in, lookup_in;

    logic        lookup_taken, valid_out, taken_out, mispred_out, illegal_out;
    logic [31:0] next_pc_out;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        s_lookup_taken, s_valid, s_taken, s_mispred, s_illegal;
    logic [31:0] s_next_pc;
    logic [2:0]  s_branch_cnt, s_mispred_cnt;

    typedef struct {
        logic        valid;
        logic        taken;
        logic        mispred;
        logic        illegal;
        logic [31:0] npc;
        int          bcnt;
        int          mcnt;
        int          sbcnt;
        int          smcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    int bht_m [64];
    int bcnt_m, mcnt_m, sbcnt_m, smcnt_m;

    always #5 clk = ~clk;

    rv32_branch_resolve_unit dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .valid_in        (valid_in),
        .opcode_in       (opcode_in),
        .funct3_in       (funct3_in),
        .pc_in           (pc_in),
        .imm_in          (imm_in),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .pred_next_pc_in (pred_in),
        .flush_in        (flush_in),
        .lookup_pc_in    (lookup_in),
        .lookup_taken_out(lookup_taken),
        .valid_out       (valid_out),
        .taken_out       (taken_out),
        .next_pc_out     (next_pc_out),
        .mispredict_out  (mispred_out),
        .illegal_out     (illegal_out),
        .branch_cnt_out  (branch_cnt),
        .mispred_cnt_out (mispred_cnt)
    );

    rv32_branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(4), .CNT_W(3)) dut_small (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .valid_in        (valid_in),
        .opcode_in       (opcode_in),
        .funct3_in       (funct3_in),
        .pc_in           (pc_in),
        .imm_in          (imm_in),
        .rs1_in          (rs1_in),
        .rs2_in          (rs2_in),
        .pred_next_pc_in (pred_in),
        .flush_in        (flush_in),
        .lookup_pc_in    (lookup_in),
        .lookup_taken_out(s_lookup_taken),
        .valid_out       (s_valid),
        .taken_out       (s_taken),
        .next_pc_out     (s_next_pc),
        .mispredict_out  (s_mispred),
        .illegal_out     (s_illegal),
        .branch_cnt_out  (s_branch_cnt),
        .mispred_cnt_out (s_mispred_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        bcnt_m  = 0;
        mcnt_m  = 0;
        sbcnt_m = 0;
        smcnt_m = 0;
        exp_q.delete();
    endtask

    // Drive one cycle of inputs, check the pre-update lookup, queue the expected result
    task automatic applyStimulus(input logic v, input logic fl, input logic [4:0] op,
                                 input logic [2:0] f3, input logic [31:0] pc,
                                 input logic [31:0] imm, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] pred,
                                 input logic [31:0] lk);
        exp_t        e;
        logic        isb, isj, isjr, cond, ill, tk;
        logic [31:0] npc;
        @(negedge clk);
        valid_in  = v;
        flush_in  = fl;
        opcode_in = op;
        funct3_in = f3;
        pc_in     = pc;
        imm_in    = imm;
        rs1_in    = a;
        rs2_in    = b;
        pred_in   = pred;
        lookup_in = lk;
        #1;
        checkOutput("lookup_taken", {63'd0, lookup_taken}, {63'd0, (bht_m[lk[7:2]] >= 2)});
        e = '{valid: 1'b0, taken: 1'b0, mispred: 1'b0, illegal: 1'b0, npc: 32'd0,
              bcnt: 0, mcnt: 0, sbcnt: 0, smcnt: 0};
        isb  = (op == OP_BR);
        isj  = (op == OP_JAL);
        isjr = (op == OP_JALR);
        if (v && !fl && (isb || isj || isjr)) begin
            ill = isb && (f3 == 3'd2 || f3 == 3'd3);
            case (f3)
                3'd0:    cond = (a == b);
                3'd1:    cond = (a != b);
                3'd4:    cond = ($signed(a) <  $signed(b));
                3'd5:    cond = ($signed(a) >= $signed(b));
                3'd6:    cond = (a <  b);
                3'd7:    cond = (a >= b);
                default: cond = 1'b0;
            endcase
            tk = isj || isjr || (isb && !ill && cond);
            if (isjr)    npc = (a + imm) & 32'hFFFF_FFFE;
            else if (tk) npc = pc + imm;
            else         npc = pc + 32'd4;
            e.valid   = 1'b1;
            e.taken   = tk;
            e.illegal = ill;
            e.npc     = npc;
            e.mispred = (npc != pred);
            if (isb && !ill) begin
                bcnt_m  = (bcnt_m  < 65535) ? bcnt_m + 1 : bcnt_m;
                sbcnt_m = (sbcnt_m < 7)     ? sbcnt_m + 1 : sbcnt_m;
                if (tk) bht_m[pc[7:2]] = (bht_m[pc[7:2]] < 3) ? bht_m[pc[7:2]] + 1 : 3;
                else    bht_m[pc[7:2]] = (bht_m[pc[7:2]] > 0) ? bht_m[pc[7:2]] - 1 : 0;
            end
            if (e.mispred) begin
                mcnt_m  = (mcnt_m  < 65535) ? mcnt_m + 1 : mcnt_m;
                smcnt_m = (smcnt_m < 7)     ? smcnt_m + 1 : smcnt_m;
            end
        end
        e.bcnt  = bcnt_m;
        e.mcnt  = mcnt_m;
        e.sbcnt = sbcnt_m;
        e.smcnt = smcnt_m;
        exp_q.push_back(e);
    endtask

    // Monitor: after each capture edge compare the registered outputs with the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("valid_out",   {63'd0, valid_out},   {63'd0, mon_e.valid});
                checkOutput("taken_out",   {63'd0, taken_out},   {63'd0, mon_e.taken});
                checkOutput("next_pc_out", {32'd0, next_pc_out}, {32'd0, mon_e.npc});
                checkOutput("mispredict",  {63'd0, mispred_out}, {63'd0, mon_e.mispred});
                checkOutput("illegal_out", {63'd0, illegal_out}, {63'd0, mon_e.illegal});
                checkOutput("branch_cnt",  {48'd0, branch_cnt},  64'(mon_e.bcnt));
                checkOutput("mispred_cnt", {48'd0, mispred_cnt}, 64'(mon_e.mcnt));
                checkOutput("s_branch_cnt",  {61'd0, s_branch_cnt},  64'(mon_e.sbcnt));
                checkOutput("s_mispred_cnt", {61'd0, s_mispred_cnt}, 64'(mon_e.smcnt));
                checkOutput("s_valid",       {63'd0, s_valid},       {63'd0, mon_e.valid});
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"},   {63'd0, valid_out},   64'd0);
        checkOutput({tag, "_taken"},   {63'd0, taken_out},   64'd0);
        checkOutput({tag, "_next_pc"}, {32'd0, next_pc_out}, 64'd0);
        checkOutput({tag, "_mispred"}, {63'd0, mispred_out}, 64'd0);
        checkOutput({tag, "_illegal"}, {63'd0, illegal_out}, 64'd0);
        checkOutput({tag, "_bcnt"},    {48'd0, branch_cnt},  64'd0);
        checkOutput({tag, "_mcnt"},    {48'd0, mispred_cnt}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            lookup_in = $urandom();
            #1;
            checkOutput({tag, "_lookup"}, {63'd0, lookup_taken}, 64'd0);
        end
    endtask

    initial begin
        logic [31:0] rpc, rimm, ra, rb, rpred;
        logic [4:0]  rop;
        int          sel;

        rst_n     = 1'b0;
        valid_in  = 1'b0;
        flush_in  = 1'b0;
        opcode_in = 5'd0;
        funct3_in = 3'd0;
        pc_in     = 32'd0;
        imm_in    = 32'd0;
        rs1_in    = 32'd0;
        rs2_in    = 32'd0;
        pred_in   = 32'd0;
        lookup_in = 32'd0;
        resetModel();
        #1;
        checkAllZero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // BHT training: three taken BEQs then a not-taken one at pc 0x200
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, OP_BR, 3'd0, 32'h200, 32'h40, 32'd7, 32'd7, 32'h240, 32'h200);
        applyStimulus(0, 0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h200);
        applyStimulus(1, 0, OP_BR, 3'd0, 32'h200, 32'h40, 32'd7, 32'd8, 32'h204, 32'h200);
        applyStimulus(0, 0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h200);
        checkOutput("bht_after_nt", {63'd0, lookup_taken}, 64'd1);

        // BEQ taken with a wrong prediction
        applyStimulus(1, 0, OP_BR, 3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 32'h100);
        @(posedge clk); #2;
        checkOutput("beq_next_pc", {32'd0, next_pc_out}, 64'h120);
        checkOutput("beq_mispred", {63'd0, mispred_out}, 64'd1);

        // Signed versus unsigned less-than on the same operands
        applyStimulus(1, 0, OP_BR, 3'd4, 32'h300, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h300);
        @(posedge clk); #2;
        checkOutput("blt_taken", {63'd0, taken_out}, 64'd1);
        applyStimulus(1, 0, OP_BR, 3'd6, 32'h300, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h380, 32'h300);
        @(posedge clk); #2;
        checkOutput("bltu_taken",   {63'd0, taken_out},   64'd0);
        checkOutput("bltu_next_pc", {32'd0, next_pc_out}, 64'h304);

        // JALR clears bit 0 and leaves the BHT alone
        applyStimulus(1, 0, OP_JALR, 3'd0, 32'h404, 32'd0, 32'h1003, 32'd0, 32'h1002, 32'h404);
        @(posedge clk); #2;
        checkOutput("jalr_next_pc", {32'd0, next_pc_out}, 64'h1002);
        applyStimulus(1, 0, OP_JAL, 3'd5, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 32'd0, 32'h404);

        // Illegal funct3, then a flushed branch
        applyStimulus(1, 0, OP_BR, 3'd3, 32'h500, 32'h10, 32'd1, 32'd1, 32'h504, 32'h500);
        @(posedge clk); #2;
        checkOutput("illegal_flag", {63'd0, illegal_out}, 64'd1);
        applyStimulus(1, 1, OP_BR, 3'd0, 32'h500, 32'h10, 32'd1, 32'd1, 32'h0, 32'h500);

        // Reset asserted mid-cycle while a result is being presented
        applyStimulus(1, 0, OP_BR, 3'd1, 32'h600, 32'h10, 32'd1, 32'd2, 32'h0, 32'h600);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        checkAllZero("midreset");
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      rop = OP_BR;
            else if (sel == 6) rop = OP_JAL;
            else if (sel == 7) rop = OP_JALR;
            else               rop = 5'($urandom());
            rpc  = {22'd0, 8'($urandom()), 2'b00};
            rimm = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom()))) : $urandom();
            ra   = ($urandom_range(0, 1) == 1) ? 32'($signed(4'($urandom()))) : $urandom();
            rb   = ($urandom_range(0, 2) == 0) ? ra : 32'($signed(4'($urandom())));
            case ($urandom_range(0, 2))
                0:       rpred = rpc + 32'd4;
                1:       rpred = rpc + rimm;
                default: rpred = $urandom();
            endcase
            applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), rop,
                          3'($urandom()), rpc, rimm, ra, rb, rpred,
                          {22'd0, 8'($urandom()), 2'b00});
        end

        @(posedge clk); #2;
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("small_bcnt_sat", {61'd0, s_branch_cnt}, 64'd7);
        checkOutput("small_mcnt_sat", {61'd0, s_mispred_cnt}, 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
